// File: rtl/adc_snap_sched_pkg.sv
// Shared types and constants for the ADC snapshot scheduler.
// Used by adc_snap_sched and adc_snap_timer.
package adc_snap_sched_pkg;

  localparam int FIFO_DEPTH     = 16;
  localparam int MAX_CH         = 8;
  localparam int SNAP_HDR_WORDS = 1;
  localparam int CNT_W          = 16;
  localparam int PERIOD_W       = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_REQ   = 2'd2
  } sched_state_e;

  // A channel count of 0 selects every channel; larger counts are clamped.
  function automatic logic [4:0] words_needed(input logic [3:0] num_ch);
    logic [4:0] eff;
    if (num_ch == 4'd0 || num_ch > 4'(MAX_CH)) begin
      eff = 5'(MAX_CH);
    end else begin
      eff = {1'b0, num_ch};
    end
    return eff + 5'(SNAP_HDR_WORDS);
  endfunction

  function automatic logic [4:0] fifo_free(input logic [4:0] level);
    logic [4:0] free_words;
    if (level >= 5'(FIFO_DEPTH)) begin
      free_words = 5'd0;
    end else begin
      free_words = 5'(FIFO_DEPTH) - level;
    end
    return free_words;
  endfunction

endpackage

// File: rtl/adc_snap_timer.sv
// Periodic snapshot timer: emits a one-cycle tick every period_cfg clocks
// while enabled; held at zero otherwise.
module adc_snap_timer
  import adc_snap_sched_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_enable,
  input  logic [PERIOD_W-1:0] i_period,
  output logic                o_tick
);

  logic [PERIOD_W-1:0] r_cnt;
  logic                w_run;
  logic                w_hit;

  // Compare with >= so a period shrunk below the count fires immediately.
  always_comb begin
    w_run = i_enable && (i_period != {PERIOD_W{1'b0}});
    w_hit = w_run && (r_cnt >= (i_period - {{(PERIOD_W-1){1'b0}}, 1'b1}));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= {PERIOD_W{1'b0}};
    end else if (!w_run || w_hit) begin
      r_cnt <= {PERIOD_W{1'b0}};
    end else begin
      r_cnt <= r_cnt + {{(PERIOD_W-1){1'b0}}, 1'b1};
    end
  end

  assign o_tick = w_hit;

endmodule

// File: rtl/adc_snap_sched.sv
// ADC snapshot scheduler: coalesces software, start and timer requests into
// snapshot requests. Define ADC_SNAP_SCHED_SPACE_GUARD_EN to enable the FIFO space check.
module adc_snap_sched
  import adc_snap_sched_pkg::*;
(
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic                ctrl_enable,
  input  logic                ctrl_start,
  input  logic                sw_snap,
  input  logic [PERIOD_W-1:0] period_cfg,
  input  logic [3:0]          num_ch,
  input  logic [4:0]          fifo_level,
  input  logic                snap_ack,
  output logic                snap_req,
  output logic                sched_busy,
  output logic [CNT_W-1:0]    snap_seq,
  output logic [CNT_W-1:0]    skip_cnt,
  output logic                skip_pulse
);

  sched_state_e     r_state;
  sched_state_e     w_next_state;
  logic             r_p_sw;
  logic             r_p_start;
  logic             r_p_tick;
  logic             w_tick;
  logic             w_any_pending;
  logic             w_take;
  logic             w_space_ok;
  logic             w_seq_inc;
  logic             r_snap_req;
  logic             r_busy;
  logic [CNT_W-1:0] r_seq;

  adc_snap_timer u_timer (
    .i_clk    (wb_clk_i),
    .i_rst_n  (wb_rst_ni),
    .i_enable (ctrl_enable),
    .i_period (period_cfg),
    .o_tick   (w_tick)
  );

`ifdef ADC_SNAP_SCHED_SPACE_GUARD_EN
  always_comb begin
    w_space_ok = fifo_free(fifo_level) >= words_needed(num_ch);
  end
`else
  logic w_unused_guard;
  assign w_unused_guard = ^{fifo_level, num_ch};
  always_comb begin
    w_space_ok = 1'b1;
  end
`endif

  always_comb begin
    w_any_pending = r_p_sw || r_p_start || r_p_tick;
    w_take        = (r_state == ST_IDLE) && w_any_pending;
  end

  // Pending flags: cleared when IDLE hands off to CHECK, but a source seen
  // on that same edge survives into the next service.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_p_sw    <= 1'b0;
      r_p_start <= 1'b0;
      r_p_tick  <= 1'b0;
    end else begin
      r_p_sw    <= w_take ? sw_snap    : (r_p_sw    || sw_snap);
      r_p_start <= w_take ? ctrl_start : (r_p_start || ctrl_start);
      if (!ctrl_enable) begin
        r_p_tick <= 1'b0;
      end else begin
        r_p_tick <= w_take ? w_tick : (r_p_tick || w_tick);
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_any_pending) begin
          w_next_state = ST_CHECK;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (w_space_ok) begin
          w_next_state = ST_REQ;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (snap_ack) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_REQ;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_seq_inc = (r_state == ST_REQ) && snap_ack;
  end

  // Outputs are registered from the next state so they track the state register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_snap_req <= 1'b0;
      r_busy     <= 1'b0;
      r_seq      <= {CNT_W{1'b0}};
    end else begin
      r_snap_req <= (w_next_state == ST_REQ);
      r_busy     <= (w_next_state != ST_IDLE);
      if (w_seq_inc) begin
        r_seq <= r_seq + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        r_seq <= r_seq;
      end
    end
  end

`ifdef ADC_SNAP_SCHED_SPACE_GUARD_EN
  logic             w_skip;
  logic             r_skip_pulse;
  logic [CNT_W-1:0] r_skip_cnt;

  always_comb begin
    w_skip = (r_state == ST_CHECK) && !w_space_ok;
  end

  // Skip counter saturates so a stalled consumer cannot wrap it back to zero.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_skip_pulse <= 1'b0;
      r_skip_cnt   <= {CNT_W{1'b0}};
    end else begin
      r_skip_pulse <= w_skip;
      if (w_skip && (r_skip_cnt != {CNT_W{1'b1}})) begin
        r_skip_cnt <= r_skip_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        r_skip_cnt <= r_skip_cnt;
      end
    end
  end

  assign skip_pulse = r_skip_pulse;
  assign skip_cnt   = r_skip_cnt;
`else
  assign skip_pulse = 1'b0;
  assign skip_cnt   = {CNT_W{1'b0}};
`endif

  assign snap_req   = r_snap_req;
  assign sched_busy = r_busy;
  assign snap_seq   = r_seq;

endmodule

// File: tb/tb_adc_snap_sched.sv
// Directed, table-driven bench for adc_snap_sched; drives and samples on the
// falling clock edge. Guard expectations follow ADC_SNAP_SCHED_SPACE_GUARD_EN.
module tb_adc_snap_sched;

`ifdef ADC_SNAP_SCHED_SPACE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        ctrl_enable;
  logic        ctrl_start;
  logic        sw_snap;
  logic [23:0] period_cfg;
  logic [3:0]  num_ch;
  logic [4:0]  fifo_level;
  logic        snap_ack;
  logic        snap_req;
  logic        sched_busy;
  logic [15:0] snap_seq;
  logic [15:0] skip_cnt;
  logic        skip_pulse;

  int n_chk;
  int n_err;
  int exp_seq;
  int exp_skip;

  adc_snap_sched dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .ctrl_enable (ctrl_enable),
    .ctrl_start  (ctrl_start),
    .sw_snap     (sw_snap),
    .period_cfg  (period_cfg),
    .num_ch      (num_ch),
    .fifo_level  (fifo_level),
    .snap_ack    (snap_ack),
    .snap_req    (snap_req),
    .sched_busy  (sched_busy),
    .snap_seq    (snap_seq),
    .skip_cnt    (skip_cnt),
    .skip_pulse  (skip_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       use_start;
    logic [3:0] ch;
    logic [4:0] lvl;
    logic       fits;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic exp_req;
    exp_req = !GUARD || v.fits;
    num_ch = v.ch;
    fifo_level = v.lvl;
    if (v.use_start) ctrl_start = 1'b1;
    else sw_snap = 1'b1;
    @(negedge clk);
    ctrl_start = 1'b0;
    sw_snap = 1'b0;
    chk("idle_after_sample", 32'(sched_busy), 32'd0);
    @(negedge clk);
    chk("busy_in_check", 32'(sched_busy), 32'd1);
    chk("no_req_in_check", 32'(snap_req), 32'd0);
    @(negedge clk);
    chk("req_2clk", 32'(snap_req), 32'(exp_req));
    chk("skip_pulse", 32'(skip_pulse), 32'(!exp_req));
    if (!exp_req) exp_skip++;
    chk("skip_cnt", 32'(skip_cnt), 32'(exp_skip));
    if (exp_req) begin
      @(negedge clk);
      @(negedge clk);
      chk("req_held", 32'(snap_req), 32'd1);
      snap_ack = 1'b1;
      @(negedge clk);
      snap_ack = 1'b0;
      exp_seq++;
      chk("req_drop_after_ack", 32'(snap_req), 32'd0);
      chk("seq_after_ack", 32'(snap_seq), 32'(exp_seq));
      chk("idle_after_ack", 32'(sched_busy), 32'd0);
    end else begin
      @(negedge clk);
      chk("skip_pulse_1cyc", 32'(skip_pulse), 32'd0);
      chk("idle_after_skip", 32'(sched_busy), 32'd0);
    end
    @(negedge clk);
  endtask

  initial begin
    int rise_t[8];
    int nr;
    logic prev;

    n_chk = 0; n_err = 0; exp_seq = 0; exp_skip = 0;
    rst_n = 1'b0; ctrl_enable = 1'b0; ctrl_start = 1'b0; sw_snap = 1'b0;
    period_cfg = 24'd0; num_ch = 4'd4; fifo_level = 5'd0; snap_ack = 1'b0;

    // fits = (16 - lvl) >= 1 + eff_ch, eff_ch = 8 for ch 0 or >8
    vecs[0] = '{1'b0, 4'd4,  5'd0,  1'b1};
    vecs[1] = '{1'b1, 4'd0,  5'd7,  1'b1};
    vecs[2] = '{1'b0, 4'd8,  5'd8,  1'b0};
    vecs[3] = '{1'b0, 4'd12, 5'd8,  1'b0};
    vecs[4] = '{1'b1, 4'd1,  5'd14, 1'b1};
    vecs[5] = '{1'b0, 4'd3,  5'd13, 1'b0};
    vecs[6] = '{1'b0, 4'd8,  5'd16, 1'b0};

    @(negedge clk);
    @(negedge clk);
    chk("rst_req", 32'(snap_req), 32'd0);
    chk("rst_busy", 32'(sched_busy), 32'd0);
    chk("rst_seq", 32'(snap_seq), 32'd0);
    chk("rst_skip_cnt", 32'(skip_cnt), 32'd0);
    chk("rst_skip_pulse", 32'(skip_pulse), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    snap_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    snap_ack = 1'b0;
    chk("ack_idle_seq", 32'(snap_seq), 32'(exp_seq));
    chk("ack_idle_busy", 32'(sched_busy), 32'd0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Coalesce: sw+start together, tick arrives while REQ is held.
    num_ch = 4'd4; fifo_level = 5'd0; period_cfg = 24'd6;
    ctrl_enable = 1'b1; sw_snap = 1'b1; ctrl_start = 1'b1;
    nr = 0; prev = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 1) begin sw_snap = 1'b0; ctrl_start = 1'b0; end
      if (i == 7) ctrl_enable = 1'b0;
      if (snap_req && !prev) nr++;
      prev = snap_req;
      snap_ack = snap_req && (i >= 6);
    end
    snap_ack = 1'b0;
    exp_seq += 2;
    chk("coalesce_rises", 32'(nr), 32'd2);
    chk("coalesce_seq", 32'(snap_seq), 32'(exp_seq));

    // Periodic: period 10, immediate ack.
    period_cfg = 24'd10; ctrl_enable = 1'b1;
    nr = 0; prev = 1'b0;
    for (int i = 1; i <= 53; i++) begin
      @(negedge clk);
      if (snap_req && !prev && nr < 8) begin rise_t[nr] = i; nr++; end
      prev = snap_req;
      snap_ack = snap_req;
    end
    ctrl_enable = 1'b0;
    snap_ack = 1'b0;
    exp_seq += 5;
    chk("periodic_rises", 32'(nr), 32'd5);
    chk("periodic_first", 32'(rise_t[0]), 32'd12);
    for (int k = 1; k < 5; k++) chk("periodic_interval", 32'(rise_t[k] - rise_t[k-1]), 32'd10);
    chk("periodic_seq", 32'(snap_seq), 32'(exp_seq));
    repeat (15) @(negedge clk);
    chk("disabled_seq", 32'(snap_seq), 32'(exp_seq));
    chk("disabled_busy", 32'(sched_busy), 32'd0);

    // Shrink period below the running count: fires on the next cycle.
    period_cfg = 24'd20; ctrl_enable = 1'b1;
    nr = 0; prev = 1'b0; rise_t[0] = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 10) period_cfg = 24'd5;
      if (i == 13) ctrl_enable = 1'b0;
      if (snap_req && !prev && nr < 8) begin rise_t[nr] = i; nr++; end
      prev = snap_req;
      snap_ack = snap_req;
    end
    snap_ack = 1'b0;
    exp_seq += 1;
    chk("shrink_rises", 32'(nr), 32'd1);
    chk("shrink_first", 32'(rise_t[0]), 32'd13);
    chk("shrink_seq", 32'(snap_seq), 32'(exp_seq));

    // Reset while snap_req is high.
    fifo_level = 5'd0; num_ch = 4'd4;
    sw_snap = 1'b1;
    @(negedge clk);
    sw_snap = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_req", 32'(snap_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_req_drop", 32'(snap_req), 32'd0);
    chk("async_busy_drop", 32'(sched_busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_seq = 0; exp_skip = 0;
    chk("post_rst_seq", 32'(snap_seq), 32'd0);
    chk("post_rst_skip", 32'(skip_cnt), 32'd0);
    nr = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (snap_req || sched_busy) nr++;
    end
    chk("post_rst_quiet", 32'(nr), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
